// File: rtl/cache_ram_arbiter.sv
// Round-robin arbiter that shares one external RAM port among the cache's per-bank
// RAM channels, with a single outstanding transaction and a sticky timeout flag.
module cache_ram_arbiter #(
    parameter int NUM_BANKS = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int TIMEOUT   = 1024
) (
    input  logic                           CLK,
    input  logic                           RST,
    input  logic [NUM_BANKS-1:0]           bank_REN,
    input  logic [NUM_BANKS-1:0]           bank_WEN,
    input  logic [NUM_BANKS*ADDR_W-1:0]    bank_addr,
    input  logic [NUM_BANKS*DATA_W-1:0]    bank_store,
    output logic [NUM_BANKS*DATA_W-1:0]    bank_data,
    output logic [NUM_BANKS-1:0]           bank_complete,
    output logic                           mem_REN,
    output logic                           mem_WEN,
    output logic [ADDR_W-1:0]              mem_addr,
    output logic [DATA_W-1:0]              mem_store,
    input  logic [DATA_W-1:0]              mem_data,
    input  logic                           mem_ready,
    output logic                           busy,
    output logic [$clog2(NUM_BANKS)-1:0]   grant_id,
    output logic                           timeout_err
);

    localparam int IDX_W = $clog2(NUM_BANKS);
    localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [NUM_BANKS-1:0] LANE0 = NUM_BANKS'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MEM  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    logic [IDX_W-1:0]  rr_ptr;
    logic [CNT_W-1:0]  wait_cnt;
    logic [DATA_W-1:0] data_latch;

    logic [NUM_BANKS-1:0] req;
    logic                 pick_valid;
    logic [IDX_W-1:0]     pick_idx;
    logic [IDX_W-1:0]     scan_idx;

    assign req = bank_REN | bank_WEN;

    // First requester at or above rr_ptr, wrapping; power-of-two banks wrap for free.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            scan_idx = rr_ptr + IDX_W'(i);
            if (!pick_valid && req[scan_idx]) begin
                pick_valid = 1'b1;
                pick_idx   = scan_idx;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            wait_cnt      <= '0;
            data_latch    <= '0;
            grant_id      <= '0;
            mem_REN       <= 1'b0;
            mem_WEN       <= 1'b0;
            mem_addr      <= '0;
            mem_store     <= '0;
            busy          <= 1'b0;
            bank_complete <= '0;
            timeout_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        grant_id  <= pick_idx;
                        mem_addr  <= bank_addr[pick_idx*ADDR_W +: ADDR_W];
                        mem_store <= bank_store[pick_idx*DATA_W +: DATA_W];
                        mem_WEN   <= bank_WEN[pick_idx];
                        mem_REN   <= ~bank_WEN[pick_idx];
                        busy      <= 1'b1;
                        wait_cnt  <= CNT_ONE;
                        if (TIMEOUT == 1) begin
                            timeout_err <= 1'b1;
                        end
                        state     <= MEM;
                    end
                end
                MEM: begin
                    // wait_cnt already counts the current MEM cycle, so the flag rises on cycle TIMEOUT.
                    if (mem_ready) begin
                        data_latch    <= mem_WEN ? '0 : mem_data;
                        mem_REN       <= 1'b0;
                        mem_WEN       <= 1'b0;
                        bank_complete <= LANE0 << grant_id;
                        state         <= DONE;
                    end else if (TIMEOUT != 0 && wait_cnt != CNT_MAX) begin
                        wait_cnt <= wait_cnt + CNT_ONE;
                        if (wait_cnt + CNT_ONE == CNT_MAX) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    bank_complete <= '0;
                    busy          <= 1'b0;
                    rr_ptr        <= grant_id + IDX_W'(1);
                    state         <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        bank_data = '0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (bank_complete[i]) begin
                bank_data[i*DATA_W +: DATA_W] = data_latch;
            end
        end
    end

endmodule
